// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree.
//   op_e        : per-beat reduction operation (2-bit encoding carried with each beat)
//   identity    : per-bit identity of an operation; callers replicate it to lane width
//   apply       : per-bit binary operator used by the fold
//   clog2       : ceiling log2, returns 0 for n <= 1
//   elems_after : number of elements left after folding n elements for a number of levels
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  // Identity bit of each operator. A lane of WIDTH bits pads with {WIDTH{identity(op)}}.
  function automatic logic identity(op_e op);
    return (op == OP_AND) || (op == OP_XNOR);
  endfunction

  function automatic logic apply(op_e op, logic a, logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic int clog2(int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Each level pairs adjacent elements; an odd leftover survives as its own element.
  function automatic int elems_after(int n, int levels);
    int m;
    m = n;
    for (int i = 0; i < levels; i++) m = (m + 1) / 2;
    return m;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_stage.sv
// One pipeline slice of the reduction tree: a combinational fold of M_IN lanes over
// FOLD tree levels down to M_OUT lanes, followed by a stall-enabled register carrying
// data, op and valid.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   advance           global pipeline enable; registers hold when low
//   in_valid, in_op   beat valid and operation entering this slice
//   in_data           M_IN lanes, lane i at [i*WIDTH +: WIDTH]
//   q_valid, q_op     registered valid and operation
//   q_data            M_OUT registered lanes
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int M_IN  = 2,
  parameter int M_OUT = 1,
  parameter int WIDTH = 4,
  parameter int FOLD  = 1,
  parameter bit LAST  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance,
  input  logic                   in_valid,
  input  logic [1:0]             in_op,
  input  logic [M_IN*WIDTH-1:0]  in_data,
  output logic                   q_valid,
  output logic [1:0]             q_op,
  output logic [M_OUT*WIDTH-1:0] q_data
);

  function automatic logic [WIDTH-1:0] app(op_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = apply(op, a[i], b[i]);
    return r;
  endfunction

  op_e                    op;
  op_e                    fold_op;
  logic [WIDTH-1:0]       pad;
  logic [WIDTH-1:0]       work [M_IN];
  logic [M_OUT*WIDTH-1:0] folded;
  int                     cnt;
  int                     b_idx;

  // NOTE: every variable this block writes gets a value before any read on every pass,
  // so no storage is implied and the block stays purely combinational.
  always_comb begin
    op = op_e'(in_op);
    // XNOR folds as XOR (zero padding) and is inverted once at the output slice;
    // chaining pairwise XNORs would not equal the reduction ~^ of all lanes.
    fold_op = (op == OP_XNOR) ? OP_XOR : op;
    pad     = {WIDTH{identity(fold_op)}};
    for (int i = 0; i < M_IN; i++) work[i] = in_data[i*WIDTH +: WIDTH];
    cnt   = M_IN;
    b_idx = 0;
    // In-place fold: element j is built from 2j and 2j+1, which lie at or above j
    // and are therefore not yet overwritten in this level.
    for (int l = 0; l < FOLD; l++) begin
      for (int j = 0; j < (M_IN + 1) / 2; j++) begin
        if (j < (cnt + 1) / 2) begin
          b_idx   = (2 * j + 1 < M_IN) ? 2 * j + 1 : 2 * j;
          work[j] = app(fold_op, work[2*j], (2 * j + 1 < cnt) ? work[b_idx] : pad);
        end
      end
      cnt = (cnt + 1) / 2;
    end
    for (int k = 0; k < M_OUT; k++) folded[k*WIDTH +: WIDTH] = work[k];
    if (LAST && (op == OP_XNOR)) folded[WIDTH-1:0] = ~folded[WIDTH-1:0];
  end

  // NOTE: data and op are reset along with valid because the output slice must read
  // zero after reset; state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_op    <= 2'b00;
      q_data  <= '0;
    end else if (advance) begin
      q_valid <= in_valid;
      q_op    <= in_op;
      q_data  <= folded;
    end
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined bitwise reduction of N lanes of WIDTH bits into one WIDTH-bit result,
// with a runtime-selected operation and a valid/ready handshake.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    input handshake; in_ready is the global advance
//   in_op                 00 AND, 01 OR, 10 XOR, 11 XNOR
//   in_data               N lanes, lane i at [i*WIDTH +: WIDTH]
//   out_valid, out_ready  output handshake
//   out_data, out_op      reduced result and the op that produced it
// Latency is max(1, ceil(clog2(N)/REG_EVERY)) cycles, one beat per cycle throughput.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH     = 4,
  parameter int REG_EVERY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_op
);

  localparam int LEVELS = clog2(N);
  localparam int LAT    = (LEVELS == 0) ? 1 : (LEVELS + REG_EVERY - 1) / REG_EVERY;

  // Stall is global: every slice moves together or holds, so bubbles never collapse.
  logic advance;
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int M_IN  = elems_after(N, s * REG_EVERY);
    localparam int M_OUT = elems_after(N, (s + 1) * REG_EVERY);

    logic                   v_in;
    logic [1:0]             op_in;
    logic [M_IN*WIDTH-1:0]  d_in;
    logic                   v_q;
    logic [1:0]             op_q;
    logic [M_OUT*WIDTH-1:0] d_q;

    if (s == 0) begin : g_head
      assign v_in  = in_valid;
      assign op_in = in_op;
      assign d_in  = in_data;
    end else begin : g_link
      assign v_in  = g_stage[s-1].v_q;
      assign op_in = g_stage[s-1].op_q;
      assign d_in  = g_stage[s-1].d_q;
    end

    reduce_stage #(
      .M_IN  (M_IN),
      .M_OUT (M_OUT),
      .WIDTH (WIDTH),
      .FOLD  (REG_EVERY),
      .LAST  (s == LAT - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (advance),
      .in_valid (v_in),
      .in_op    (op_in),
      .in_data  (d_in),
      .q_valid  (v_q),
      .q_op     (op_q),
      .q_data   (d_q)
    );
  end

  assign out_valid = g_stage[LAT-1].v_q;
  assign out_op    = g_stage[LAT-1].op_q;
  assign out_data  = g_stage[LAT-1].d_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Drives four configurations in lock step from one stimulus stream:
//   0: N=8 REG_EVERY=1 (LAT 3)   1: N=5 (LAT 3)   2: N=1 (LAT 1)   3: N=8 REG_EVERY=2 (LAT 2)
// Each instance has its own in_valid so a beat is offered until that instance takes it,
// and its own scoreboard queue filled by the driver at acceptance.
module tb_reduce_tree_pipe;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] op;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [3:0]  e8;
    logic [3:0]  e5;
    logic [3:0]  e1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [3:0]  iv;
  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0]  od [4];
  logic [1:0]  oo [4];

  int   total = 0;
  int   bad   = 0;
  int   n_out [4] = '{0, 0, 0, 0};
  int   exp_lat [4] = '{3, 3, 1, 2};
  exp_t q0[$], q1[$], q2[$], q3[$];
  vec_t tbl [10];

  always #5 clk = ~clk;

  reduce_tree_pipe #(.N(8), .WIDTH(4), .REG_EVERY(1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_op(in_op),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_op(oo[0]));
  reduce_tree_pipe #(.N(5), .WIDTH(4), .REG_EVERY(1)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_op(in_op),
    .in_data(in_data[19:0]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_op(oo[1]));
  reduce_tree_pipe #(.N(1), .WIDTH(4), .REG_EVERY(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_op(in_op),
    .in_data(in_data[3:0]), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_op(oo[2]));
  reduce_tree_pipe #(.N(8), .WIDTH(4), .REG_EVERY(2)) u_n8r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]), .in_op(in_op),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .out_op(oo[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Linear reference reduction over the first n lanes; XNOR is the inverted XOR of all lanes.
  function automatic logic [3:0] model(input logic [1:0] op, input logic [31:0] d, input int n);
    logic [3:0] acc;
    acc = (op == 2'b00) ? 4'hF : 4'h0;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00:   acc = acc & d[4*i +: 4];
        2'b01:   acc = acc | d[4*i +: 4];
        default: acc = acc ^ d[4*i +: 4];
      endcase
    end
    if (op == 2'b11) acc = ~acc;
    return acc;
  endfunction

  task automatic pop_exp(input int x, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (x)
      0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() != 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int pending();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  // Output side of the scoreboard: every output transfer must match the oldest accepted beat.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n) begin
      for (int x = 0; x < 4; x++) begin
        if (ov[x] && out_ready) begin
          pop_exp(x, e, ok);
          if (!ok) check($sformatf("spurious_out_dut%0d", x), 32'(ov[x]), 32'(0));
          else begin
            check($sformatf("out_data_dut%0d", x), 32'(od[x]), 32'(e.data));
            check($sformatf("out_op_dut%0d", x), 32'(oo[x]), 32'(e.op));
            n_out[x]++;
          end
        end
      end
    end
  end

  // Offers one beat to all instances and returns at posedge+1 once every instance took it.
  task automatic drive(input logic [1:0] op, input logic [31:0] data,
                       input logic [3:0] e8, input logic [3:0] e5,
                       input logic [3:0] e1, input logic [3:0] e82);
    logic [3:0] acc;
    int budget;
    budget  = 50;
    in_op   = op;
    in_data = data;
    iv      = 4'hF;
    while (iv != 4'h0 && budget > 0) begin
      @(negedge clk);
      acc = iv & rdy;
      if (acc[0]) q0.push_back({e8, op});
      if (acc[1]) q1.push_back({e5, op});
      if (acc[2]) q2.push_back({e1, op});
      if (acc[3]) q3.push_back({e82, op});
      @(posedge clk);
      #1;
      iv = iv & ~acc;
      budget--;
    end
    if (iv != 4'h0) begin
      check("drive_accept_timeout", 32'(iv), 32'(0));
      iv = 4'h0;
    end
  endtask

  task automatic drive_rand();
    logic [1:0]  op;
    logic [31:0] data;
    op   = 2'($urandom_range(0, 3));
    data = $urandom;
    drive(op, data, model(op, data, 8), model(op, data, 5), model(op, data, 1), model(op, data, 8));
  endtask

  task automatic drive_vec(input int i);
    drive(tbl[i].op, tbl[i].data, tbl[i].e8, tbl[i].e5, tbl[i].e1, tbl[i].e8);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(pending()), 32'(0));
  endtask

  // Single beat into empty pipelines; records the cycle at which each out_valid appears.
  task automatic probe(input int i);
    int lat [4];
    lat = '{0, 0, 0, 0};
    drive_vec(i);
    for (int c = 1; c <= 6; c++) begin
      for (int x = 0; x < 4; x++) if (ov[x] && lat[x] == 0) lat[x] = c;
      @(posedge clk);
      #1;
    end
    for (int x = 0; x < 4; x++)
      check($sformatf("latency_vec%0d_dut%0d", i, x), 32'(lat[x]), 32'(exp_lat[x]));
  endtask

  initial begin
    int base;
    tbl[0] = '{2'b00, 32'hFFBFFFFF, 4'hB, 4'hF, 4'hF};
    tbl[1] = '{2'b01, 32'h00080021, 4'hB, 4'hB, 4'h1};
    tbl[2] = '{2'b10, 32'h00080021, 4'hB, 4'hB, 4'h1};
    tbl[3] = '{2'b00, 32'hFFFFFFFF, 4'hF, 4'hF, 4'hF};
    tbl[4] = '{2'b11, 32'h00000005, 4'hA, 4'hA, 4'hA};
    tbl[5] = '{2'b10, 32'h12345678, 4'h8, 4'h8, 4'h8};
    tbl[6] = '{2'b01, 32'h80000000, 4'h8, 4'h0, 4'h0};
    tbl[7] = '{2'b00, 32'hFFFF7FFF, 4'h7, 4'h7, 4'hF};
    tbl[8] = '{2'b11, 32'hF0000000, 4'h0, 4'hF, 4'hF};
    tbl[9] = '{2'b01, 32'h00000000, 4'h0, 4'h0, 4'h0};

    rst_n     = 1'b0;
    iv        = 4'h0;
    out_ready = 1'b1;
    in_op     = 2'b00;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(ov), 32'(0));
    check("reset_out_data", 32'(od[0]), 32'(0));
    check("reset_out_op", 32'(oo[0]), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(rdy), 32'hF);

    // Latency from empty pipelines, then the table back to back.
    probe(0);
    for (int i = 0; i < 10; i++) drive_vec(i);
    drain("table_drain");
    probe(4);

    // Ten random beats back to back; in_ready must never drop.
    base = n_out[0];
    for (int i = 0; i < 10; i++) begin
      check("stream_in_ready", 32'(rdy), 32'hF);
      drive_rand();
    end
    drain("stream_drain");
    check("stream_count", 32'(n_out[0] - base), 32'(10));

    // Backpressure: hold out_ready low, results must freeze and in_ready drop.
    base      = n_out[0];
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) drive_rand();
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!ov[0] && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("bp_out_valid", 32'(ov[0]), 32'(1));
        repeat (4) begin
          check("bp_in_ready", 32'(rdy[0]), 32'(0));
          check("bp_hold_data", 32'(od[0]), 32'((q0.size() != 0) ? q0[0].data : 4'hx));
          check("bp_hold_op", 32'(oo[0]), 32'((q0.size() != 0) ? q0[0].op : 2'bxx));
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", 32'(n_out[0] - base), 32'(5));

    // Reset with three beats in flight: everything is discarded.
    for (int i = 0; i < 3; i++) drive_rand();
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    #1;
    check("async_reset_out_valid", 32'(ov), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check("post_reset_idle", 32'(ov), 32'(0));
      @(posedge clk);
      #1;
    end
    probe(3);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
